// File: rtl/mips_pkg.sv
// mips_pkg: shared opcodes, function codes, FSM states and ALU operations for the bus CPU.
package mips_pkg;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM_RD, S_LOAD_WB, S_MEM_WR, S_HALTED
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
    } alu_op_t;

endpackage

// File: rtl/mips_cpu_bus_core_alu.sv
// mips_alu: combinational 32-bit ALU; shifts act on b by shamt, LUI places b's low half on top.
module mips_alu
    import mips_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [4:0]  i_shamt,
    input  alu_op_t     i_op,
    output logic [31:0] o_result,
    output logic        o_zero
);

    // result select per operation, all arithmetic modulo 2^32
    always_comb begin
        case (i_op)
            ALU_SUB:  o_result = i_a - i_b;
            ALU_AND:  o_result = i_a & i_b;
            ALU_OR:   o_result = i_a | i_b;
            ALU_XOR:  o_result = i_a ^ i_b;
            ALU_NOR:  o_result = ~(i_a | i_b);
            ALU_SLT:  o_result = {31'd0, $signed(i_a) < $signed(i_b)};
            ALU_SLTU: o_result = {31'd0, i_a < i_b};
            ALU_SLL:  o_result = i_b << i_shamt;
            ALU_SRL:  o_result = i_b >> i_shamt;
            ALU_SRA:  o_result = $unsigned($signed(i_b) >>> i_shamt);
            ALU_LUI:  o_result = {i_b[15:0], 16'h0000};
            default:  o_result = i_a + i_b;
        endcase
    end

    assign o_zero = (o_result == 32'd0);

endmodule

// File: rtl/mips_cpu_bus_core.sv
// mips_cpu_bus_core: multi-cycle MIPS-I subset CPU with one delay slot, mastering an Avalon-MM bus.
module mips_cpu_bus_core
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        active,
    output logic [31:0] register_v0,
    output logic [31:0] address,
    output logic        write,
    output logic        read,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);

    state_t      r_state;
    logic [31:0] r_pc, r_target, r_ir, r_address, r_writedata;
    logic        r_read, r_write, r_pending;
    logic [31:0] r_gpr [32];

    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd, w_wb_idx, w_rf_wa;
    logic [31:0] w_simm, w_zimm, w_rs_val, w_rt_val, w_pc4, w_alu_b, w_alu_result;
    logic [31:0] w_jtarget, w_pc_next, w_rf_wd;
    alu_op_t     w_alu_op;
    logic        w_alu_zero, w_wb_en, w_link, w_jump, w_beq, w_bne, w_taken;
    logic        w_is_lw, w_is_sw, w_done, w_rf_we;

    assign w_op     = r_ir[31:26];
    assign w_funct  = r_ir[5:0];
    assign w_rs     = r_ir[25:21];
    assign w_rt     = r_ir[20:16];
    assign w_rd     = r_ir[15:11];
    assign w_simm   = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_zimm   = {16'h0000, r_ir[15:0]};
    assign w_rs_val = r_gpr[w_rs];
    assign w_rt_val = r_gpr[w_rt];
    assign w_pc4    = r_pc + 32'd4;
    assign w_is_lw  = (w_op == OP_LW);
    assign w_is_sw  = (w_op == OP_SW);

    // instruction decode: ALU operation, operand b, write-back target and control transfer
    always_comb begin
        w_alu_op  = ALU_ADD;
        w_alu_b   = w_simm;
        w_wb_en   = 1'b0;
        w_wb_idx  = w_rt;
        w_link    = 1'b0;
        w_jump    = 1'b0;
        w_beq     = 1'b0;
        w_bne     = 1'b0;
        w_jtarget = w_pc4 + {w_simm[29:0], 2'b00};
        case (w_op)
            OP_SPECIAL: begin
                w_alu_b  = w_rt_val;
                w_wb_idx = w_rd;
                w_wb_en  = 1'b1;
                case (w_funct)
                    FN_ADDU: w_alu_op = ALU_ADD;
                    FN_SUBU: w_alu_op = ALU_SUB;
                    FN_AND:  w_alu_op = ALU_AND;
                    FN_OR:   w_alu_op = ALU_OR;
                    FN_XOR:  w_alu_op = ALU_XOR;
                    FN_NOR:  w_alu_op = ALU_NOR;
                    FN_SLT:  w_alu_op = ALU_SLT;
                    FN_SLTU: w_alu_op = ALU_SLTU;
                    FN_SLL:  w_alu_op = ALU_SLL;
                    FN_SRL:  w_alu_op = ALU_SRL;
                    FN_SRA:  w_alu_op = ALU_SRA;
                    FN_JR: begin
                        w_wb_en   = 1'b0;
                        w_jump    = 1'b1;
                        w_jtarget = w_rs_val;
                    end
                    FN_JALR: begin
                        w_link    = 1'b1;
                        w_jump    = 1'b1;
                        w_jtarget = w_rs_val;
                    end
                    default: w_wb_en = 1'b0;
                endcase
            end
            OP_J: begin
                w_jump    = 1'b1;
                w_jtarget = {w_pc4[31:28], r_ir[25:0], 2'b00};
            end
            OP_JAL: begin
                w_jump    = 1'b1;
                w_jtarget = {w_pc4[31:28], r_ir[25:0], 2'b00};
                w_link    = 1'b1;
                w_wb_en   = 1'b1;
                w_wb_idx  = 5'd31;
            end
            OP_BEQ: begin
                w_beq    = 1'b1;
                w_alu_op = ALU_SUB;
                w_alu_b  = w_rt_val;
            end
            OP_BNE: begin
                w_bne    = 1'b1;
                w_alu_op = ALU_SUB;
                w_alu_b  = w_rt_val;
            end
            OP_ADDIU: w_wb_en = 1'b1;
            OP_SLTI: begin
                w_alu_op = ALU_SLT;
                w_wb_en  = 1'b1;
            end
            OP_SLTIU: begin
                w_alu_op = ALU_SLTU;
                w_wb_en  = 1'b1;
            end
            OP_ANDI: begin
                w_alu_op = ALU_AND;
                w_alu_b  = w_zimm;
                w_wb_en  = 1'b1;
            end
            OP_ORI: begin
                w_alu_op = ALU_OR;
                w_alu_b  = w_zimm;
                w_wb_en  = 1'b1;
            end
            OP_XORI: begin
                w_alu_op = ALU_XOR;
                w_alu_b  = w_zimm;
                w_wb_en  = 1'b1;
            end
            OP_LUI: begin
                w_alu_op = ALU_LUI;
                w_alu_b  = w_zimm;
                w_wb_en  = 1'b1;
            end
            default: ;
        endcase
    end

    mips_alu u_alu (
        .i_a      (w_rs_val),
        .i_b      (w_alu_b),
        .i_shamt  (r_ir[10:6]),
        .i_op     (w_alu_op),
        .o_result (w_alu_result),
        .o_zero   (w_alu_zero)
    );

    assign w_taken   = w_jump | (w_beq & w_alu_zero) | (w_bne & ~w_alu_zero);
    assign w_done    = (r_state == S_EXEC && !w_is_lw && !w_is_sw) || r_state == S_LOAD_WB
                       || (r_state == S_MEM_WR && !waitrequest);
    assign w_pc_next = r_pending ? r_target : w_pc4;
    assign w_rf_we   = (r_state == S_EXEC && w_wb_en) || r_state == S_LOAD_WB;
    assign w_rf_wa   = (r_state == S_LOAD_WB) ? w_rt : w_wb_idx;
    assign w_rf_wd   = (r_state == S_LOAD_WB) ? readdata : w_link ? r_pc + 32'd8 : w_alu_result;

    // control FSM and bus request registers; the request stays registered so it holds under waitrequest
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_FETCH;
            r_pc        <= RESET_VECTOR;
            r_target    <= 32'd0;
            r_pending   <= 1'b0;
            r_ir        <= 32'd0;
            r_address   <= 32'd0;
            r_writedata <= 32'd0;
            r_read      <= 1'b0;
            r_write     <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (!r_read) begin
                        r_read    <= 1'b1;
                        r_address <= r_pc;
                    end else if (!waitrequest) begin
                        r_read  <= 1'b0;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_ir    <= readdata;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (w_is_lw) begin
                        r_read    <= 1'b1;
                        r_address <= {w_alu_result[31:2], 2'b00};
                        r_state   <= S_MEM_RD;
                    end else if (w_is_sw) begin
                        r_write     <= 1'b1;
                        r_address   <= {w_alu_result[31:2], 2'b00};
                        r_writedata <= w_rt_val;
                        r_state     <= S_MEM_WR;
                    end
                end
                S_MEM_RD: begin
                    if (!waitrequest) begin
                        r_read  <= 1'b0;
                        r_state <= S_LOAD_WB;
                    end
                end
                S_MEM_WR: if (!waitrequest) r_write <= 1'b0;
                default: ;
            endcase
            if (w_done) begin
                r_pc      <= w_pc_next;
                r_target  <= w_jtarget;
                r_pending <= (r_state == S_EXEC) && w_taken;
                r_state   <= (w_pc_next == 32'd0) ? S_HALTED : S_FETCH;
            end
        end
    end

    // register file; $0 is never written so it always reads zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) r_gpr[i] <= 32'd0;
        end else if (w_rf_we && w_rf_wa != 5'd0) begin
            r_gpr[w_rf_wa] <= w_rf_wd;
        end
    end

    assign active      = (r_state != S_HALTED);
    assign register_v0 = r_gpr[2];
    assign address     = r_address;
    assign read        = r_read;
    assign write       = r_write;
    assign writedata   = r_writedata;
    assign byteenable  = 4'b1111;

endmodule

// File: tb/tb_mips_cpu_bus_core.sv
// tb_mips_cpu_bus_core: bus memory model plus instruction-level reference interpreter for the CPU.
module tb_mips_cpu_bus_core;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        waitrequest = 1'b0;
    logic [31:0] readdata = 32'd0;
    logic        active, write, read;
    logic [31:0] register_v0, address, writedata;
    logic [3:0]  byteenable;

    int          n_chk = 0, n_err = 0;
    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    logic [31:0] ref_v0, first_addr, last_wd;
    int          ref_rd, ref_wr, nrd, nwr, k;
    logic        first_seen;
    int          fns [11] = '{'h00, 'h02, 'h03, 'h21, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2A, 'h2B};
    int          ops [7]  = '{'h09, 'h0A, 'h0B, 'h0C, 'h0D, 'h0E, 'h0F};
    int          regs [5] = '{0, 2, 9, 10, 11};

    mips_cpu_bus_core dut (
        .clk         (clk),
        .reset       (reset),
        .active      (active),
        .register_v0 (register_v0),
        .address     (address),
        .write       (write),
        .read        (read),
        .waitrequest (waitrequest),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .readdata    (readdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int sh, input int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input logic [15:0] imm);
        return {6'(op), 5'(rs), 5'(rt), imm};
    endfunction

    function automatic logic [31:0] enc_j(input int op, input logic [31:0] target);
        return {6'(op), target[27:2]};
    endfunction

    // reference interpreter: pc/npc pair gives the delay slot, memory is the 256-byte window
    task automatic iss();
        logic [31:0] g [32];
        logic [31:0] pc, npc, nnpc, ins, a, b, si, zi, r, ea;
        logic [4:0]  dst;
        logic        wr;
        for (int i = 0; i < 32; i++) g[i] = 0;
        pc = 32'hBFC00000;
        npc = pc + 4;
        ref_rd = 0;
        ref_wr = 0;
        for (int steps = 0; steps < 2000 && pc != 0; steps++) begin
            ins = ref_mem[pc[7:2]];
            ref_rd++;
            a = g[ins[25:21]];
            b = g[ins[20:16]];
            si = {{16{ins[15]}}, ins[15:0]};
            zi = {16'h0, ins[15:0]};
            ea = a + si;
            nnpc = npc + 4;
            wr = 1;
            dst = ins[20:16];
            r = 0;
            case (ins[31:26])
                6'h00: begin
                    dst = ins[15:11];
                    case (ins[5:0])
                        6'h00: r = b << ins[10:6];
                        6'h02: r = b >> ins[10:6];
                        6'h03: r = $unsigned($signed(b) >>> ins[10:6]);
                        6'h08: begin wr = 0; nnpc = a; end
                        6'h09: begin r = pc + 8; nnpc = a; end
                        6'h21: r = a + b;
                        6'h23: r = a - b;
                        6'h24: r = a & b;
                        6'h25: r = a | b;
                        6'h26: r = a ^ b;
                        6'h27: r = ~(a | b);
                        6'h2A: r = ($signed(a) < $signed(b)) ? 1 : 0;
                        6'h2B: r = (a < b) ? 1 : 0;
                        default: wr = 0;
                    endcase
                end
                6'h02: begin wr = 0; nnpc = {npc[31:28], ins[25:0], 2'b00}; end
                6'h03: begin nnpc = {npc[31:28], ins[25:0], 2'b00}; r = pc + 8; dst = 31; end
                6'h04: begin wr = 0; if (a == b) nnpc = npc + (si << 2); end
                6'h05: begin wr = 0; if (a != b) nnpc = npc + (si << 2); end
                6'h09: r = a + si;
                6'h0A: r = ($signed(a) < $signed(si)) ? 1 : 0;
                6'h0B: r = (a < si) ? 1 : 0;
                6'h0C: r = a & zi;
                6'h0D: r = a | zi;
                6'h0E: r = a ^ zi;
                6'h0F: r = {ins[15:0], 16'h0};
                6'h23: begin r = ref_mem[ea[7:2]]; ref_rd++; end
                6'h2B: begin wr = 0; ref_mem[ea[7:2]] = b; ref_wr++; end
                default: wr = 0;
            endcase
            if (wr && dst != 0) g[dst] = r;
            pc = npc;
            npc = nnpc;
        end
        ref_v0 = g[2];
    endtask

    // reset, then serve the bus until halt; each request is stalled for `stall` cycles first
    task automatic run_prog(input int stall);
        int cyc, sc;
        logic held, hr, hwr;
        logic [31:0] ha, hw;
        reset = 0;
        waitrequest = 0;
        readdata = 0;
        nrd = 0;
        nwr = 0;
        first_seen = 0;
        first_addr = 0;
        repeat (2) @(negedge clk);
        reset = 1;
        cyc = 0;
        sc = 0;
        held = 0;
        while (active && cyc < 10000) begin
            @(negedge clk);
            cyc++;
            if (held) begin
                chk("hold_addr", address, ha);
                chk("hold_ctl", {writedata, read, write}, {hw, hr, hwr});
            end
            if (read || write) begin
                if (!first_seen) begin
                    first_addr = address;
                    first_seen = 1;
                end
                if (sc < stall) begin
                    waitrequest = 1;
                    sc++;
                    held = 1;
                    ha = address;
                    hr = read;
                    hwr = write;
                    hw = writedata;
                end else begin
                    waitrequest = 0;
                    held = 0;
                    sc = 0;
                    chk("addr_window", {address[31:8], address[1:0]}, {24'hBFC000, 2'b00});
                    chk("rw_exclusive", read & write, 0);
                    chk("byteenable", byteenable, 4'hF);
                    if (read) begin
                        readdata = mem[address[7:2]];
                        nrd++;
                    end else begin
                        mem[address[7:2]] = writedata;
                        last_wd = writedata;
                        nwr++;
                    end
                end
            end else begin
                waitrequest = 0;
                held = 0;
                sc = 0;
            end
        end
        chk("halted_active", active, 0);
        chk("halted_bus", {read, write}, 2'b00);
    endtask

    task automatic run_check(input string name, input int stall);
        int mis;
        ref_mem = mem;
        iss();
        run_prog(stall);
        chk({name, "_v0"}, register_v0, ref_v0);
        chk({name, "_reads"}, nrd, ref_rd);
        chk({name, "_writes"}, nwr, ref_wr);
        mis = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) mis++;
        chk({name, "_mem"}, mis, 0);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 0;
        mem[0] = enc_i('h0F, 0, 8, 16'hBFC0);
    endtask

    task automatic load_xor(input logic [31:0] w2);
        clear_mem();
        mem[1] = enc_i('h23, 8, 9, 16'h002C);
        mem[2] = enc_i('h23, 8, 10, 16'h0030);
        mem[3] = enc_r(0, 0, 0, 0, 'h08);
        mem[4] = enc_r(9, 10, 2, 0, 'h26);
        mem[11] = 32'h00FF00FF;
        mem[12] = w2;
    endtask

    initial begin
        load_xor(32'h00FF00FF);
        run_check("xor_equal", 0);
        chk("xor_equal_const", register_v0, 32'h0);

        load_xor(32'h0F0F0F0F);
        run_check("xor_diff", 0);
        chk("xor_diff_const", register_v0, 32'h0FF00FF0);

        load_xor(32'h0F0F0F0F);
        run_check("xor_stall", 3);
        chk("xor_stall_const", register_v0, 32'h0FF00FF0);

        clear_mem();
        mem[1] = enc_i('h09, 0, 3, 16'h1234);
        mem[2] = enc_i('h2B, 8, 3, 16'h0040);
        mem[3] = enc_i('h23, 8, 2, 16'h0040);
        mem[4] = enc_r(0, 0, 0, 0, 'h08);
        run_check("store", 1);
        chk("store_count", nwr, 1);
        chk("store_data", last_wd, 32'h00001234);
        chk("store_v0_const", register_v0, 32'h00001234);

        for (int i = 0; i < 64; i++) mem[i] = 0;
        mem[0] = enc_i('h04, 0, 0, 16'h0002);
        mem[1] = enc_i('h09, 0, 2, 16'h0001);
        mem[2] = enc_i('h09, 2, 2, 16'h0010);
        mem[3] = enc_i('h09, 2, 2, 16'h0004);
        mem[4] = enc_r(0, 0, 0, 0, 'h08);
        run_check("branch", 0);
        chk("branch_v0_const", register_v0, 32'd5);

        load_xor(32'h0F0F0F0F);
        reset = 0;
        waitrequest = 1;
        @(negedge clk);
        reset = 1;
        k = 0;
        while (!read && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("midfetch_req", read, 1);
        #2 reset = 0;
        #1;
        chk("midfetch_read", read, 0);
        chk("midfetch_active", active, 1);
        chk("midfetch_addr", address, 32'h0);
        run_check("after_reset", 2);
        chk("first_fetch_addr", first_addr, 32'hBFC00000);

        for (int t = 0; t < 6; t++) begin
            clear_mem();
            mem[1] = enc_i('h23, 8, 9, 16'h0080);
            mem[2] = enc_i('h23, 8, 10, 16'h0084);
            for (int i = 3; i < 23; i++)
                mem[i] = $urandom_range(0, 1)
                    ? enc_r(regs[$urandom_range(0, 4)], regs[$urandom_range(0, 4)], regs[$urandom_range(0, 4)],
                            $urandom_range(0, 31), fns[$urandom_range(0, 10)])
                    : enc_i(ops[$urandom_range(0, 6)], regs[$urandom_range(0, 4)], regs[$urandom_range(0, 4)],
                            16'($urandom));
            mem[23] = enc_r(0, 0, 0, 0, 'h08);
            mem[32] = $urandom;
            mem[33] = $urandom;
            run_check("rand_alu", $urandom_range(0, 2));
        end

        for (int t = 0; t < 4; t++) begin
            clear_mem();
            mem[1]  = enc_i('h23, 8, 9, 16'h0080);
            mem[2]  = enc_i('h23, 8, 10, 16'h0084);
            mem[3]  = enc_i('h05, 9, 10, 16'h0002);
            mem[4]  = enc_i('h09, 0, 2, 16'h0007);
            mem[5]  = enc_i('h09, 2, 2, 16'h0064);
            mem[6]  = enc_j('h03, 32'hBFC0002C);
            mem[7]  = enc_i('h09, 2, 2, 16'h0001);
            mem[8]  = enc_r(0, 0, 4, 0, 'h09);
            mem[9]  = enc_r(2, 4, 2, 0, 'h23);
            mem[11] = enc_i('h09, 0, 11, 16'h0003);
            mem[12] = enc_r(31, 0, 0, 0, 'h08);
            mem[13] = enc_r(2, 11, 2, 0, 'h21);
            mem[32] = $urandom;
            mem[33] = $urandom_range(0, 1) ? mem[32] : $urandom;
            run_check("ctrl", $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mips_cpu_bus_core.md
Name: mips_cpu_bus_core

Overview:
- Multi-cycle MIPS-I subset CPU (32-bit, big picture: single memory-mapped bus master) with an Avalon-MM style bus interface.
- Fetches from reset vector 0xBFC00000, executes with one architectural branch delay slot, and halts when control transfers to address 0.
- Exposes register $2 ($v0) for test observation.
- Top of the CPU hierarchy; the bench supplies the memory.

Parameters:
- RESET_VECTOR, 32'hBFC00000, PC value after reset.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- active  out  1  high while CPU running; low once halted.
- register_v0  out  32  live copy of GPR $2.
- address  out  32  byte address, always word-aligned (bits[1:0]=0).
- write  out  1  write request.
- read  out  1  read request.
- waitrequest  in  1  slave stall; request must be held unchanged while high.
- writedata  out  32  store data.
- byteenable  out  4  byte lanes; 4'b1111 for every access in this subset.
- readdata  in  32  read data, valid in the cycle after the accepted read.

Behaviour:
- Reset (reset low, async):
  - PC=RESET_VECTOR; all 32 GPRs=0; state=FETCH.
  - active=1, read=0, write=0, address=0, writedata=0, byteenable=4'b1111.
  - Reset mid-operation aborts any bus request immediately.
- Request acceptance: a request is accepted at a rising edge where read or write is high and waitrequest is low. While waitrequest is high, address, writedata, byteenable, read and write are held stable. read and write are never high together.
- States:
  - FETCH: read=1, address=PC; on accept go to DECODE.
  - DECODE: latch IR=readdata, read GPRs.
  - EXEC: ALU operation, then
    - to MEM_RD for LW;
    - to MEM_WR for SW;
    - otherwise write back and go to FETCH.
  - MEM_RD: read=1, address=rs+signext(imm); on accept go to LOAD_WB.
  - LOAD_WB: rt=readdata; go to FETCH.
  - MEM_WR: write=1, writedata=rt, same address form; on accept go to FETCH.
  - HALTED: read=write=0, active=0; stay until reset.
- Halt rule: on entry to FETCH with PC==0, go to HALTED instead of issuing a read. active drops the cycle HALTED is entered. Any instructions before the transfer, including its delay slot, complete first.
- Delay slot: branch/jump computes a target and sets a pending flag. The next sequential instruction executes, then PC=target. Otherwise PC=PC+4 after each instruction.
- Instruction subset:
  - R-type: ADDU, SUBU, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, JR, JALR.
  - I-type: ADDIU, SLTIU, SLTI, ANDI, ORI, XORI, LUI, LW, SW, BEQ, BNE.
  - J-type: J, JAL.
- Arithmetic and immediates:
  - All arithmetic is 32-bit modulo 2^32; no overflow traps.
  - ANDI, ORI and XORI zero-extend the immediate; all others sign-extend.
  - LUI writes {imm,16'h0}.
  - Branch target = PC+4+(signext(imm)<<2).
  - J target = {PC+4[31:28], idx, 2'b00}.
  - JAL and JALR write PC+8 to the link register ($31 for JAL, rd for JALR).
- $0 ignores writes and reads 0.
- Unsupported opcodes execute as NOP.
- Load-use: a value loaded into rt is visible to the immediately following instruction (no hazard; multi-cycle).
- register_v0 reflects $2 combinationally from the register file; reset value 0.

Decomposition:
- Package mips_pkg holds:
  - opcode/funct localparams;
  - the state enum (FETCH, DECODE, EXEC, MEM_RD, LOAD_WB, MEM_WR, HALTED);
  - an ALU-op enum;
  - the RESET_VECTOR default.
- One sub-module: mips_alu, combinational (a, b, shamt, op -> result, zero).
- Register file and FSM stay in the top module.

Test Plan:
- XOR program at 0xBFC00000:
  - LUI $8,0xBFC0; LW $9,0x2C($8); LW $10,0x30($8); JR $0; XOR $2,$9,$10 (delay slot).
  - Words at +0x2C and +0x30 both 0x00FF00FF.
  - Required: register_v0=0x00000000 and active=0 well before 10000 cycles.
- Same program with second word 0x0F0F0F0F -> register_v0=0x0FF00FF0.
- Waitrequest stall: hold waitrequest high 3 cycles on every request.
  - Required: address and read stay stable throughout.
  - Required: same final v0; no duplicate accesses.
- Store/load round trip:
  - ADDIU $3,$0,0x1234; SW $3,0x40($8); LW $2,0x40($8); JR $0; NOP.
  - Required: one write with byteenable=4'b1111, writedata=0x00001234.
  - Required: register_v0=0x00001234.
- Branch delay slot:
  - BEQ $0,$0,+2; ADDIU $2,$0,1 (slot); ADDIU $2,$2,16 (skipped); target ADDIU $2,$2,4; JR $0; NOP.
  - Required: register_v0=5.
- Reset mid-fetch:
  - Assert reset while read=1 and waitrequest=1.
  - Required: read drops immediately and active=1.
  - Required: after release, first read is at address 0xBFC00000.
